// File: rtl/register_file.sv
// ============================================================================
// register_file : 2-read / 1-write register file, register 0 hard-wired to 0
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS] = '{default: '0};

  // Per-entry write decode: an unknown address with RegWrite low cannot
  // select any entry, so no register can be disturbed.
  always_ff @(posedge clk) begin
    r_regs[0] <= '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else if (RegWrite && (WriteRegister == 5'(i))) begin
        r_regs[i] <= WriteData;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] f_stored(input logic [4:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if ((addr != 5'd0) && (32'(addr) < NUM_REGS)) begin
      v = r_regs[addr];
    end
    return v;
  endfunction

  logic [DATA_WIDTH-1:0] w_stored1;
  logic [DATA_WIDTH-1:0] w_stored2;

  always_comb begin
    w_stored1 = f_stored(ReadRegister1);
    w_stored2 = f_stored(ReadRegister2);
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic w_wr_live;
  logic w_byp1;
  logic w_byp2;

  always_comb begin
    w_wr_live = RegWrite && !reset && (WriteRegister != 5'd0);
    w_byp1    = w_wr_live && (ReadRegister1 == WriteRegister);
    w_byp2    = w_wr_live && (ReadRegister2 == WriteRegister);
    ReadData1 = w_byp1 ? WriteData : w_stored1;
    ReadData2 = w_byp2 ? WriteData : w_stored2;
  end
`else
  always_comb begin
    ReadData1 = w_stored1;
    ReadData2 = w_stored2;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed + randomized checks against an array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [DW-1:0] WriteData;
  logic [4:0]    ReadRegister1;
  logic [4:0]    ReadRegister2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [32];

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file #(.DATA_WIDTH(DW), .NUM_REGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value: stored model value, or forwarded write data when
  // the bypass build sees a live non-zero write to the same address.
  function automatic logic [DW-1:0] exp_read(input logic [4:0] ra);
    if (BYPASS && RegWrite && !reset && WriteRegister != 5'd0 && ra == WriteRegister)
      return WriteData;
    return (ra == 5'd0) ? '0 : model[ra];
  endfunction

  // Apply one rising edge with the current inputs, updating the model.
  task automatic do_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [DW-1:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    @(negedge clk);

    // Reset, then every address must read 0 on both ports
    set_in(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    do_edge();
    set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 5'd0, '0, 5'(a), 5'(31 - a));
      chk("reset_sweep_p1", ReadData1, '0);
      chk("reset_sweep_p2", ReadData2, '0);
    end

    // Write reg 8, read on both ports; neighbour stays 0
    set_in(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0);
    do_edge();
    set_in(1'b0, 1'b0, 5'd0, '0, 5'd8, 5'd8);
    chk("reg8_p1", ReadData1, 32'hDEADBEEF);
    chk("reg8_p2", ReadData2, 32'hDEADBEEF);
    set_in(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd8);
    chk("reg9_zero", ReadData1, '0);

    // Write to reg 0 is discarded
    set_in(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    chk("reg0_during_write", ReadData1, '0);
    do_edge();
    set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    chk("reg0_after_write", ReadData1, '0);

    // Read-during-write on reg 5
    set_in(1'b0, 1'b1, 5'd5, 32'h1, 5'd0, 5'd0);
    do_edge();
    set_in(1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd0);
    chk("rdw_pre_edge", ReadData1, BYPASS ? 32'hA5A5A5A5 : 32'h1);
    do_edge();
    chk("rdw_post_edge", ReadData1, 32'hA5A5A5A5);

    // Reset wins over a simultaneous write
    set_in(1'b0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd8);
    do_edge();
    set_in(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd8);
    chk("reset_no_bypass", ReadData1, 32'h33);
    do_edge();
    set_in(1'b0, 1'b0, 5'd3, '0, 5'd3, 5'd8);
    chk("reset_drops_write", ReadData1, '0);
    chk("reset_clears_reg8", ReadData2, '0);

    // RegWrite=0 holds reg 31, including with an unknown address
    set_in(1'b0, 1'b1, 5'd31, 32'h11, 5'd0, 5'd0);
    do_edge();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 1'b0, 5'd31, 32'h22, 5'd31, 5'd31);
      do_edge();
      chk("hold_reg31", ReadData1, 32'h11);
    end
    set_in(1'b0, 1'b0, 5'bxxxxx, 32'h22, 5'd31, 5'd0);
    do_edge();
    chk("x_addr_hold", ReadData1, 32'h11);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic          rst, we;
      logic [4:0]    wa, r1, r2;
      logic [DW-1:0] wd;
      rst = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 2) != 0;
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      if (!we && $urandom_range(0, 9) == 0) wa = 5'bxxxxx;
      set_in(rst, we, wa, wd, r1, r2);
      chk("rand_pre_p1", ReadData1, exp_read(r1));
      chk("rand_pre_p2", ReadData2, exp_read(r2));
      do_edge();
      chk("rand_post_p1", ReadData1, exp_read(r1));
      chk("rand_post_p2", ReadData2, exp_read(r2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
